seq_multiplier: RTL

Multi-cycle unsigned shift-add multiplier, the multiplicative counterpart to the existing combinational divider.
- Serves the MULT/MULTU path of the execute stage: the stage issues a `start` pulse, waits on `busy`, and takes the product on `done`.
- Processes one multiplier bit per clock.
- Replaces a large combinational array with a small sequential datapath.

---
 rtl/mult_pkg.sv | 13 +
 rtl/seq_multiplier.sv | 116 +++++++++++
 2 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier and its execute-stage integration.
package mult_pkg;

    localparam int MULT_WIDTH  = 16;
    localparam int MULT_PROD_W = 2 * MULT_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per clock.
// Optional MULT_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    mult_state_e        r_state;
    mult_state_e        w_state_next;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [PW-1:0]      r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [PW-1:0]      r_p;

    logic [PW-1:0]      w_acc_next;
    logic [WIDTH-1:0]   w_mplier_next;
    logic               w_last;
    logic               w_busy;
    logic               w_done;

    // The multiplicand is pre-extended to PW bits, so the add can never carry out.
    assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_next = r_mplier >> 1;

`ifdef MULT_EARLY_EXIT_EN
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (w_mplier_next == '0);
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // p is only written on the edge that leaves RUN, so it holds across later RUN phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= PW'(a);
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_p <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = w_busy;
    assign done = w_done;
    assign p    = r_p;

endmodule
